// File: rtl/clock_monitor_pkg.sv
// Shared state encodings and counter-width helper for the clock monitor.
package clock_monitor_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_EVAL    = 2'd2;

   typedef enum logic [1:0] {
      StIdle    = ST_IDLE,
      StMeasure = ST_MEASURE,
      StEval    = ST_EVAL
   } state_e;

   // Bits needed to hold every value in 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/clock_monitor_sync_edge_detect.sv
// Two-flop synchronizer plus previous-value register; emits a one-cycle pulse on a rising input.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= async_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/clock_monitor.sv
// Counts rising edges of a sampled external clock per window and flags loss or out-of-range rate.
module clock_monitor
   import clock_monitor_pkg::*;
#(
   parameter int unsigned WINDOW    = 1024,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MIN_EDGES = 500,
   parameter int unsigned MAX_EDGES = 520,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic             mon_clk_i,
   input  logic             ack_i,
   output logic [CNT_W-1:0] edge_count_o,
   output logic             count_valid_o,
   output logic             clk_ok_o,
   output logic             clk_lost_o,
   output logic             freq_err_o
);

   localparam int unsigned WinW = cnt_width(WINDOW - 1);
   localparam int unsigned ToW  = cnt_width(TIMEOUT);

   localparam logic [WinW-1:0]  WinLast  = WinW'(WINDOW - 1);
   localparam logic [ToW-1:0]   ToMax    = ToW'(TIMEOUT);
   localparam logic [CNT_W-1:0] CntMax   = '1;
   localparam logic [CNT_W-1:0] MinEdges = CNT_W'(MIN_EDGES);
   localparam logic [CNT_W-1:0] MaxEdges = CNT_W'(MAX_EDGES);

   state_e           state_q, state_d;
   logic [WinW-1:0]  win_q, win_d;
   logic [CNT_W-1:0] edges_q, edges_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ToW-1:0]   to_q, to_d;
   logic             valid_q, valid_d;
   logic             ok_q, ok_d;
   logic             lost_q, lost_d;
   logic             ferr_q, ferr_d;
   logic             rise;
   logic             in_range;

   sync_edge_detect u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (mon_clk_i),
      .rise_o  (rise)
   );

   assign in_range = (edges_q >= MinEdges) && (edges_q <= MaxEdges);

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      edges_d = edges_q;
      count_d = count_q;
      to_d    = to_q;
      valid_d = 1'b0;
      ok_d    = ok_q;
      lost_d  = lost_q & ~ack_i;
      ferr_d  = ferr_q & ~ack_i;

      if (!enable_i) begin
         state_d = StIdle;
         win_d   = '0;
         edges_d = '0;
         to_d    = '0;
         ok_d    = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StMeasure;
               win_d   = '0;
               edges_d = '0;
               to_d    = '0;
            end
            StMeasure: begin
               if (rise && (edges_q != CntMax)) begin
                  edges_d = edges_q + 1'b1;
               end
               if (win_q == WinLast) begin
                  state_d = StEval;
               end else begin
                  win_d = win_q + 1'b1;
               end
            end
            StEval: begin
               count_d = edges_q;
               valid_d = 1'b1;
               ok_d    = in_range;
               if (!in_range) begin
                  ferr_d = 1'b1;
               end
               win_d   = '0;
               // An edge landing in this cycle opens the next window.
               edges_d = CNT_W'(rise);
               state_d = StMeasure;
            end
            default: state_d = StIdle;
         endcase

         if (state_q != StIdle) begin
            if (rise) begin
               to_d = '0;
            end else if (to_q != ToMax) begin
               to_d = to_q + 1'b1;
            end
            if (to_d == ToMax) begin
               ok_d = 1'b0;
               if (to_q != ToMax) begin
                  lost_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         win_q   <= '0;
         edges_q <= '0;
         count_q <= '0;
         to_q    <= '0;
         valid_q <= 1'b0;
         ok_q    <= 1'b0;
         lost_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         edges_q <= edges_d;
         count_q <= count_d;
         to_q    <= to_d;
         valid_q <= valid_d;
         ok_q    <= ok_d;
         lost_q  <= lost_d;
         ferr_q  <= ferr_d;
      end
   end

   assign edge_count_o  = count_q;
   assign count_valid_o = valid_q;
   assign clk_ok_o      = ok_q;
   assign clk_lost_o    = lost_q;
   assign freq_err_o    = ferr_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: per-cycle samples of the monitored clock feed an edge-counting model.
module tb_clock_monitor;

   localparam int unsigned WINDOW    = 1024;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned MIN_EDGES = 500;
   localparam int unsigned MAX_EDGES = 520;
   localparam int unsigned TIMEOUT   = 64;
   localparam int          HistLen   = 32768;
   localparam int          Per       = WINDOW + 1;

   logic             clk       = 1'b0;
   logic             rst       = 1'b0;
   logic             enable_i  = 1'b0;
   logic             mon_clk_i = 1'b0;
   logic             ack_i     = 1'b0;
   logic [CNT_W-1:0] edge_count_o;
   logic             count_valid_o;
   logic             clk_ok_o;
   logic             clk_lost_o;
   logic             freq_err_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit hist [HistLen];
   int mon_mode = 1;  // 0 stopped, 1/2 fixed half-period in cycles, 3 random half-period

   int e_start;
   int win_idx;
   int last_p;
   int last_exp_cnt;
   bit exp_ferr;
   bit exp_lost;
   bit last_ok;

   clock_monitor #(
      .WINDOW    (WINDOW),
      .CNT_W     (CNT_W),
      .MIN_EDGES (MIN_EDGES),
      .MAX_EDGES (MAX_EDGES),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable_i      (enable_i),
      .mon_clk_i     (mon_clk_i),
      .ack_i         (ack_i),
      .edge_count_o  (edge_count_o),
      .count_valid_o (count_valid_o),
      .clk_ok_o      (clk_ok_o),
      .clk_lost_o    (clk_lost_o),
      .freq_err_o    (freq_err_o)
   );

   initial begin
      forever #5 clk = ~clk;
   end

   // The synchronizer sees zeros while reset is held.
   always @(posedge clk) begin
      if (cyc < HistLen) hist[cyc] <= rst ? 1'b0 : mon_clk_i;
      cyc <= cyc + 1;
   end

   initial begin : mon_gen
      int ph;
      int half;
      ph   = 0;
      half = 1;
      forever begin
         @(negedge clk);
         if (mon_mode == 0) begin
            mon_clk_i = 1'b0;
            ph        = 0;
         end else if (ph + 1 >= half) begin
            mon_clk_i = ~mon_clk_i;
            ph        = 0;
            half      = (mon_mode == 3) ? int'($urandom_range(3, 1)) : mon_mode;
         end else begin
            ph++;
         end
      end
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   // Number of rises the DUT should count at clk edges lo..hi (detect lags the sample by 2 edges).
   function automatic int rises(input int lo, input int hi);
      int n;
      n = 0;
      for (int q = lo; q <= hi; q++) begin
         if (q >= 3 && q - 2 < HistLen && hist[q-2] && !hist[q-3]) n++;
      end
      return n;
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_edge(input int target);
      while (cyc - 1 < target) tick();
   endtask

   task automatic check_window(output int dut_cnt);
      int p;
      int lo;
      int budget;
      int cnt;
      bit inr;
      bit pend;
      p      = e_start + (win_idx + 1) * Per;
      budget = 0;
      do begin
         tick();
         budget++;
      end while (!count_valid_o && budget < Per + 40);
      check("pulse_seen", count_valid_o, 1);
      check("pulse_edge", cyc - 1, p);
      lo   = (win_idx == 0) ? e_start + 1 : e_start + win_idx * Per;
      cnt  = rises(lo, p - 1);
      inr  = (cnt >= int'(MIN_EDGES)) && (cnt <= int'(MAX_EDGES));
      pend = (p - e_start >= int'(TIMEOUT)) && (rises(p - int'(TIMEOUT) + 1, p) == 0);
      if (!inr) exp_ferr = 1'b1;
      last_ok = inr && !pend;
      check("edge_count", edge_count_o, cnt);
      check("clk_ok", clk_ok_o, last_ok);
      check("freq_err", freq_err_o, exp_ferr);
      check("clk_lost", clk_lost_o, exp_lost);
      dut_cnt      = int'(edge_count_o);
      last_exp_cnt = cnt;
      last_p       = p;
      win_idx++;
   endtask

   task automatic do_ack();
      ack_i = 1'b1;
      tick();
      ack_i    = 1'b0;
      exp_ferr = 1'b0;
      exp_lost = 1'b0;
      check("ack_freq_err", freq_err_o, 0);
      check("ack_clk_lost", clk_lost_o, 0);
   endtask

   initial begin : stim
      int c0;
      int c1;
      int l_edge;
      bit seen;
      exp_ferr = 1'b0;
      exp_lost = 1'b0;
      last_ok  = 1'b0;
      win_idx  = 0;
      e_start  = 0;
      last_p   = 0;

      // Reset values
      #1 rst = 1'b1;
      #1;
      check("rst_count", edge_count_o, 0);
      check("rst_valid", count_valid_o, 0);
      check("rst_ok", clk_ok_o, 0);
      check("rst_lost", clk_lost_o, 0);
      check("rst_ferr", freq_err_o, 0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();
      check("idle_valid", count_valid_o, 0);
      check("idle_ok", clk_ok_o, 0);

      // Nominal 20 ns monitored clock; the odd period puts a rise in one of the two EVAL cycles
      e_start = cyc;
      win_idx = 0;
      enable_i = 1'b1;
      check_window(c0);
      check_window(c1);
      check("nominal_w0_512", (c0 >= 511 && c0 <= 513), 1);
      check("nominal_w1_512", (c1 >= 511 && c1 <= 513), 1);
      check("two_window_sum", c0 + c1, rises(e_start + 1, last_p - 1));

      // Slow clock, ack, then set-wins when ack coincides with EVAL
      mon_mode = 2;
      check_window(c0);
      do_ack();
      wait_edge(last_p + Per - 1);
      ack_i = 1'b1;
      check_window(c1);
      ack_i = 1'b0;
      check("slow_256", (c1 >= 255 && c1 <= 257), 1);
      mon_mode = 1;
      check_window(c0);
      do_ack();
      check_window(c0);

      // Stopped clock
      wait_edge(last_p + 200);
      mon_mode = 0;
      repeat (4) tick();
      l_edge = last_p;
      for (int q = cyc - 1; q > last_p; q--) begin
         if (rises(q, q) != 0) begin
            l_edge = q;
            break;
         end
      end
      wait_edge(l_edge + int'(TIMEOUT) - 1);
      check("lost_before_timeout", clk_lost_o, 0);
      check("ok_before_timeout", clk_ok_o, last_ok);
      tick();
      check("lost_at_timeout", clk_lost_o, 1);
      check("ok_at_timeout", clk_ok_o, 0);
      exp_lost = 1'b1;
      repeat (100) tick();
      mon_mode = 1;
      check_window(c0);
      check_window(c0);
      do_ack();

      // Enable drop at window cycle 300
      check_window(c0);
      wait_edge(last_p + 300);
      enable_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (count_valid_o) seen = 1'b1;
      end
      check("drop_no_pulse", seen, 0);
      check("drop_ok", clk_ok_o, 0);
      check("drop_hold_count", edge_count_o, last_exp_cnt);
      check("drop_hold_ferr", freq_err_o, exp_ferr);
      e_start  = cyc;
      win_idx  = 0;
      enable_i = 1'b1;
      check_window(c0);

      // Asynchronous reset mid-window, between clock edges
      repeat (500) tick();
      #1 rst = 1'b1;
      #1;
      check("arst_count", edge_count_o, 0);
      check("arst_valid", count_valid_o, 0);
      check("arst_ok", clk_ok_o, 0);
      check("arst_lost", clk_lost_o, 0);
      check("arst_ferr", freq_err_o, 0);
      exp_ferr = 1'b0;
      exp_lost = 1'b0;
      tick();
      tick();
      #1 rst = 1'b0;
      e_start = cyc;
      win_idx = 0;
      check_window(c0);

      // Randomized monitored clock
      mon_mode = 3;
      check_window(c0);
      check_window(c1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
